mem_ctrl: RTL

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 50 +++++
 rtl/mem_ctrl_if.sv | 19 +
 rtl/mem_ctrl_load_ext.sv | 22 ++
 rtl/mem_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared opcode/funct3 encodings and FSM state type for the memory stage.
package mem_ctrl_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic logic access_valid(input logic [6:0] opcode, input logic [2:0] funct3);
    logic ok;
    ok = 1'b0;
    if (opcode == OP_LOAD) begin
      case (funct3)
        FUNCT3_LB, FUNCT3_LH, FUNCT3_LW, FUNCT3_LBU, FUNCT3_LHU: ok = 1'b1;
        default: ok = 1'b0;
      endcase
    end else if (opcode == OP_STORE) begin
      case (funct3)
        FUNCT3_SB, FUNCT3_SH, FUNCT3_SW: ok = 1'b1;
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // Index of the final byte of the access (n-1).
  function automatic logic [1:0] last_cnt(input logic [2:0] funct3);
    logic [1:0] lc;
    case (funct3[1:0])
      2'b01:   lc = 2'd1;
      2'b10:   lc = 2'd3;
      default: lc = 2'd0;
    endcase
    return lc;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Byte-wide req/ack RAM port between the memory stage and its RAM.
interface mem_ctrl_if;
  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        ram_ack;

  modport master (
    output ram_req, ram_we, ram_addr, ram_wdata,
    input  ram_rdata, ram_ack
  );

  modport slave (
    input  ram_req, ram_we, ram_addr, ram_wdata,
    output ram_rdata, ram_ack
  );
endinterface

// File: rtl/mem_ctrl_load_ext.sv
// Sign/zero extension of an assembled load value according to funct3.
module load_ext
  import mem_ctrl_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] raw_i,
  output logic [31:0] ext_o
);

  always_comb begin
    ext_o = '0;
    case (funct3_i)
      FUNCT3_LB:  ext_o = {{24{raw_i[7]}}, raw_i[7:0]};
      FUNCT3_LH:  ext_o = {{16{raw_i[15]}}, raw_i[15:0]};
      FUNCT3_LW:  ext_o = raw_i;
      FUNCT3_LBU: ext_o = {24'h000000, raw_i[7:0]};
      FUNCT3_LHU: ext_o = {16'h0000, raw_i[15:0]};
      default:    ext_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Memory stage: performs loads/stores one byte per RAM transfer, stalling the
// pipeline until the access completes; other instructions pass straight through.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_reg_data_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq,
  mem_ctrl_if.master  ram
);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] result_q;
  logic [31:0] load_val;
  logic        load_byte_en;

  logic        is_load, is_store, is_mem, valid;

  logic        req_c, we_c;
  logic [31:0] addr_c;
  logic [7:0]  wdata_c;
  logic        stall_c;

  assign is_load  = (opcode_i == OP_LOAD);
  assign is_store = (opcode_i == OP_STORE);
  assign is_mem   = is_load | is_store;
  assign valid    = access_valid(opcode_i, funct3_i);

  assign wd_o   = wd_i;
  assign wreg_o = wreg_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_byte_en) begin
        result_q[{cnt_q, 3'b000} +: 8] <= ram.ram_rdata;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    load_byte_en = 1'b0;
    req_c        = 1'b0;
    we_c         = 1'b0;
    addr_c       = '0;
    wdata_c      = '0;
    stall_c      = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid) begin
          state_d = ACCESS;
          cnt_d   = '0;
          stall_c = 1'b1;
        end
      end
      ACCESS: begin
        stall_c = 1'b1;
        req_c   = 1'b1;
        we_c    = is_store;
        addr_c  = mem_addr_i + {30'd0, cnt_q};
        wdata_c = mem_reg_data_i[{cnt_q, 3'b000} +: 8];
        if (ram.ram_ack) begin
          load_byte_en = is_load;
          if (cnt_q == last_cnt(funct3_i)) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are forced quiet while reset is held, independent of state.
  always_comb begin
    ram.ram_req   = req_c & ~rst;
    ram.ram_we    = we_c & ~rst;
    ram.ram_addr  = rst ? '0 : addr_c;
    ram.ram_wdata = rst ? '0 : wdata_c;
    stallreq      = stall_c & ~rst;
  end

  load_ext u_load_ext (
    .funct3_i (funct3_i),
    .raw_i    (result_q),
    .ext_o    (load_val)
  );

  always_comb begin
    wdata_o = '0;
    if (rst) begin
      wdata_o = '0;
    end else if (!is_mem) begin
      wdata_o = wdata_i;
    end else if (is_load && (state_q == DONE)) begin
      wdata_o = load_val;
    end
  end

endmodule
